// File: rtl/rs232_mem_pkg.sv
// rtl/rs232_mem_pkg.sv - shared constants, FSM encoding and command decode for rs232_mem_port
package rs232_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_DATA,
    ST_RD,
    ST_GAP,
    ST_PULSE,
    ST_BITS
  } state_t;

  localparam int         OPCODE_BIT = 7;
  localparam logic [3:0] FRAME_LEN  = 4'd9;
  localparam int         CNT_W      = 20;

  // Bits between the address field and the opcode bit must be clear.
  function automatic logic cmd_ok(input logic [7:0] cmd, input int unsigned addr_w);
    return (cmd[6:0] >> addr_w) == 7'd0;
  endfunction

endpackage

// File: rtl/rs232_mem_port_if.sv
// rtl/rs232_mem_port_if.sv - bit-serial word link between the RS232 controller and the memory port
interface rs232_mem_port_if;

  logic new_word;
  logic data_rs232_in;
  logic send_word;
  logic data_rs232_out;
  logic busy;
  logic err;

  modport master (
    output new_word, data_rs232_in,
    input  send_word, data_rs232_out, busy, err
  );

  modport slave (
    input  new_word, data_rs232_in,
    output send_word, data_rs232_out, busy, err
  );

endinterface

// File: rtl/rs232_mem_deser.sv
// rtl/rs232_mem_deser.sv - frame deserializer: header cycle, 8 data bits MSB first, framing checks
module rs232_mem_deser
  import rs232_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       new_word,
  input  logic       data_in,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  logic [3:0] cnt;

  // cnt counts high cycles of the current run; FRAME_LEN+1 marks an already-reported overlong run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= 4'd0;
      rx_byte    <= 8'd0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (new_word) begin
        if (cnt < FRAME_LEN) begin
          cnt <= cnt + 4'd1;
          if (cnt != 4'd0) rx_byte <= {rx_byte[6:0], data_in};
          if (cnt == FRAME_LEN - 4'd1) byte_valid <= 1'b1;
        end else if (cnt == FRAME_LEN) begin
          cnt       <= cnt + 4'd1;
          frame_err <= 1'b1;
        end
      end else begin
        if (cnt != 4'd0 && cnt < FRAME_LEN) frame_err <= 1'b1;
        cnt <= 4'd0;
      end
    end
  end

endmodule

// File: rtl/rs232_mem_port.sv
// rtl/rs232_mem_port.sv - command FSM, byte RAM, reply pacing and serializer for the RS232 memory port
module rs232_mem_port
  import rs232_mem_pkg::*;
#(
  parameter int ADDR_W         = 4,
  parameter int GAP_CYCLES     = 62500,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  rs232_mem_port_if.slave  link
);

  localparam logic [CNT_W-1:0] GAP_RELOAD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t              state, state_nx;
  logic                byte_valid, frame_err;
  logic [7:0]          rx_byte;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          reply;
  logic [2:0]          bit_cnt;
  logic [CNT_W-1:0]    gap_cnt, to_cnt;
  logic [7:0]          mem [2**ADDR_W];
  logic                cmd_good, gap_done, timeout, overrun, bad_cmd;

  rs232_mem_deser u_deser (
    .clk       (clk),
    .rst       (rst),
    .new_word  (link.new_word),
    .data_in   (link.data_rs232_in),
    .byte_valid(byte_valid),
    .rx_byte   (rx_byte),
    .frame_err (frame_err)
  );

  assign cmd_good = cmd_ok(rx_byte, ADDR_W);
  // The counter is reloaded to GAP-1, so reaching 1 lets PULSE land exactly GAP cycles later.
  assign gap_done = gap_cnt <= CNT_W'(1);
  assign timeout  = (state == ST_WAIT_DATA) && !byte_valid && (to_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:      if (byte_valid && cmd_good) state_nx = rx_byte[OPCODE_BIT] ? ST_WAIT_DATA : ST_RD;
      ST_WAIT_DATA: if (byte_valid) state_nx = ST_GAP;
                    else if (timeout) state_nx = ST_IDLE;
      ST_RD:        state_nx = ST_GAP;
      ST_GAP:       if (gap_done) state_nx = ST_PULSE;
      ST_PULSE:     state_nx = ST_BITS;
      ST_BITS:      if (bit_cnt == 3'd7) state_nx = ST_IDLE;
      default:      state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    overrun             = byte_valid && (state inside {ST_RD, ST_GAP, ST_PULSE, ST_BITS});
    bad_cmd             = byte_valid && (state == ST_IDLE) && !cmd_good;
    link.send_word      = (state == ST_PULSE);
    link.data_rs232_out = (state == ST_BITS) ? reply[3'd7 - bit_cnt] : 1'b0;
    link.busy           = (state != ST_IDLE);
    link.err            = frame_err | overrun | bad_cmd | timeout;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      reply   <= 8'd0;
      bit_cnt <= 3'd0;
      gap_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      if (state == ST_IDLE && byte_valid) addr_q <= rx_byte[ADDR_W-1:0];
      if (state == ST_RD) reply <= mem[addr_q];
      if (state == ST_WAIT_DATA && byte_valid) reply <= rx_byte;
      bit_cnt <= (state == ST_BITS) ? bit_cnt + 3'd1 : 3'd0;
      if (state == ST_PULSE)     gap_cnt <= GAP_RELOAD;
      else if (gap_cnt != '0)    gap_cnt <= gap_cnt - CNT_W'(1);
      to_cnt <= (state == ST_WAIT_DATA) ? to_cnt + CNT_W'(1) : '0;
    end
  end

  // RAM keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (state == ST_WAIT_DATA && byte_valid) mem[addr_q] <= rx_byte;
  end

endmodule
